instr_mem_responder: RTL
========================

// Module: instr_mem_responder
// PURPOSE
// - Instruction-memory responder serving the fetch unit's PC-driven reads through a valid/ready request/response handshake.
// - Has a byte-serial program-load port that writes memory.
// - Sits between the fetch stage (initiator) and the on-chip instruction RAM; also the boot-time program writer.
// PARAMETERS
// - ADDR_W   10   word-address width; DEPTH = 2**ADDR_W 32-bit words
// - NOP_INSTR  32'h0000_0013   instruction returned on error (addi x0,x0,0)
// PORTS
// - clk_i        in   1   clock, rising edge
// - PCrst_i      in   1   reset, asynchronous, active-low
// - req_valid_i  in   1   fetch request valid
// - req_ready_o  out  1   request accepted when req_valid_i & req_ready_o
// - req_addr_i   in   32  byte address (PC)
// - rsp_valid_o  out  1   response valid
// - rsp_ready_i  in   1   consumer accepts response
// - rsp_instr_o  out  32  instruction word
// - rsp_addr_o   out  32  byte address that produced rsp_instr_o
// - rsp_err_o    out  1   misaligned (addr[1:0]!=0) or out-of-range (addr[31:ADDR_W+2]!=0)
// - ld_start_i   in   1   1-cycle pulse: begin program load at word 0
// - ld_valid_i   in   1   load byte valid
// - ld_ready_o   out  1   load byte accepted when ld_valid_i & ld_ready_o
// - ld_byte_i    in   8   load data byte, little-endian within word
// - ld_last_i    in   1   marks final byte of image
// - ld_done_o    out  1   1-cycle pulse after final word written
// - ld_ovf_o     out  1   sticky: image exceeded DEPTH words; cleared by ld_start_i
// BEHAVIOUR
// - Reset (async, PCrst_i=0):
//   - state=RUN; response FIFO empty; rsp_valid_o=0, rsp_err_o=0, rsp_instr_o=0, rsp_addr_o=0.
//   - ld_ready_o=0, ld_done_o=0, ld_ovf_o=0; load pointer=0, byte index=0.
//   - RAM contents are not reset.
// - FSM states:
//   - RUN: serve fetch requests. ld_start_i -> DRAIN.
//   - DRAIN: req_ready_o=0. Wait until FIFO empty and no read in flight, then -> LOAD.
//   - LOAD: req_ready_o=0, ld_ready_o=1. Accepted byte k of each word goes to bits [8k+7:8k].
//     - 4th byte writes mem[ptr], then ptr++, byte index=0.
//     - Byte with ld_last_i: partial word zero-padded and written; -> RUN; ld_done_o=1 for one cycle on entry to RUN.
// - ld_start_i in DRAIN/LOAD: ignored. Reset mid-load aborts the load; the partial word is discarded; words already written are kept.
// - Overflow: ptr==DEPTH -> further word writes dropped, ld_ovf_o=1, load continues until ld_last_i.
// - Read path:
//   - Accepted request reads RAM in the next cycle; the result enters the 2-entry response FIFO.
//   - Latency: accept at cycle N -> rsp_valid_o earliest at N+1.
//   - req_ready_o = RUN & (fifo_count + inflight - pop) < 2, where pop = rsp_valid_o & rsp_ready_i.
//   - Sustains 1 req/cycle while rsp_ready_i=1.
// - Ordering: responses returned strictly in request order.
// - Handshake stability: rsp_instr_o, rsp_addr_o and rsp_err_o stay stable while rsp_valid_o=1 & rsp_ready_i=0.
// - Error requests return rsp_instr_o=NOP_INSTR, rsp_err_o=1, and consume a FIFO slot like normal requests.
// - Simultaneous push and pop on a full FIFO: both occur, count unchanged.
// - Same-cycle RAM write and read cannot occur (RUN/LOAD exclusive).
// STRUCTURE
// - Package rv_imem_pkg: imem_state_e {RUN,DRAIN,LOAD}, NOP_INSTR, rsp_t struct {instr, addr, err}.
// - Sub-module rsp_fifo2: 2-entry rsp_t FIFO with push/pop/count; FSM, load assembler and RAM live in the top.
// TESTING
// - Load bytes 13 00 00 00 | B3 00 11 00 (last) -> ld_done_o pulse; read addr 0 -> 0x00000013; read addr 4 -> 0x001100B3; rsp_err_o=0.
// - rsp_ready_i=1, requests at addr 0,4,8,12 back-to-back -> req_ready_o held 1; four responses on consecutive cycles, in order, starting 1 cycle after first accept.
// - rsp_ready_i=0, issue requests -> exactly 2 accepted, then req_ready_o=0; release -> data and addr unchanged while stalled, correct order.
// - Request addr 0x6 and addr 4*DEPTH -> rsp_err_o=1, rsp_instr_o=0x00000013, rsp_addr_o echoes the request address.
// - ld_start_i with 2 responses pending and rsp_ready_i=0 -> stays DRAIN, ld_ready_o=0; drain responses -> LOAD.
//   - Load 4*DEPTH+4 bytes -> ld_ovf_o=1; mem[0] holds the first word.
// - Assert PCrst_i=0 after 2 bytes of a load -> all outputs at reset values; previously loaded words readable unchanged.

Source files
------------

// File: rtl/rv_imem_pkg.sv
// ============================================================================
// Module : rv_imem_pkg
// Brief  : Shared types and constants for the instruction-memory responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rv_imem_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } imem_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } rsp_t;

endpackage

`default_nettype wire

// File: rtl/instr_mem_responder_rsp_fifo2.sv
// ============================================================================
// Module : rsp_fifo2
// Brief  : Two-entry response FIFO with an empty-bypass path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rsp_fifo2
    import rv_imem_pkg::*;
(
    input  logic       clk_i,
    input  logic       PCrst_i,
    input  logic       push_i,
    input  rsp_t       push_data_i,
    input  logic       pop_i,
    output logic       valid_o,
    output rsp_t       data_o,
    output logic [1:0] count_o
);

    rsp_t       r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    logic w_empty;
    logic w_store;
    logic w_take;
    rsp_t w_head;

    // An entry pushed into an empty FIFO is visible the same cycle; if it is
    // popped right away it is never stored.
    always_comb begin
        w_empty = (r_count == 2'd0);
        valid_o = ~w_empty | push_i;
        w_head  = w_empty ? push_data_i : r_mem[r_rd_ptr];
        data_o  = valid_o ? w_head : '0;
        w_store = push_i & ~(w_empty & pop_i);
        w_take  = pop_i & ~w_empty;
        count_o = r_count;
    end

    always_ff @(posedge clk_i or negedge PCrst_i) begin
        if (!PCrst_i) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_store) r_wr_ptr <= ~r_wr_ptr;
            if (w_take)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_store} - {1'b0, w_take};
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_store) r_mem[r_wr_ptr] <= push_data_i;
    end

endmodule

`default_nettype wire

// File: rtl/instr_mem_responder.sv
// ============================================================================
// Module : instr_mem_responder
// Brief  : Fetch-side instruction RAM responder with byte-serial program load.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_mem_responder #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] NOP_INSTR = rv_imem_pkg::NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        PCrst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_instr_o,
    output logic [31:0] rsp_addr_o,
    output logic        rsp_err_o,
    input  logic        ld_start_i,
    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    input  logic [7:0]  ld_byte_i,
    input  logic        ld_last_i,
    output logic        ld_done_o,
    output logic        ld_ovf_o
);

    import rv_imem_pkg::*;

    localparam int DEPTH = 2 ** ADDR_W;

    imem_state_e r_state;
    imem_state_e w_state_nxt;

    logic [31:0]     r_mem [DEPTH];
    logic [31:0]     r_rd_data;
    logic [31:0]     r_rd_addr;
    logic            r_rd_err;
    logic            r_inflight;

    logic [ADDR_W:0] r_ld_ptr;
    logic [1:0]      r_ld_idx;
    logic [23:0]     r_ld_acc;
    logic            r_ld_done;
    logic            r_ld_ovf;

    logic            w_run;
    logic            w_req_fire;
    logic            w_req_err;
    logic            w_ld_fire;
    logic            w_word_end;
    logic            w_ram_we;
    logic [31:0]     w_ld_word;
    logic            w_pop;
    logic [2:0]      w_occ;
    logic            w_fifo_valid;
    logic [1:0]      w_fifo_count;
    rsp_t            w_push_data;
    rsp_t            w_head;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or negedge PCrst_i) begin
        if (!PCrst_i) r_state <= RUN;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (ld_start_i) w_state_nxt = DRAIN;
            DRAIN:   if ((w_fifo_count == 2'd0) && !r_inflight) w_state_nxt = LOAD;
            LOAD:    if (w_ld_fire && ld_last_i) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    // Occupancy counts the read in flight so a FIFO slot is reserved for it.
    always_comb begin
        w_run       = (r_state == RUN);
        ld_ready_o  = (r_state == LOAD);
        w_pop       = w_fifo_valid & rsp_ready_i;
        w_occ       = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
        req_ready_o = w_run & (w_occ < 3'd2);
    end

    // ---------------- Read path ----------------
    assign w_req_fire = req_valid_i & req_ready_o;
    assign w_req_err  = (|req_addr_i[1:0]) | (|req_addr_i[31:ADDR_W+2]);

    always_ff @(posedge clk_i or negedge PCrst_i) begin
        if (!PCrst_i) begin
            r_inflight <= 1'b0;
            r_rd_addr  <= 32'h0;
            r_rd_err   <= 1'b0;
        end else begin
            r_inflight <= w_req_fire;
            if (w_req_fire) begin
                r_rd_addr <= req_addr_i;
                r_rd_err  <= w_req_err;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_ram_we)   r_mem[r_ld_ptr[ADDR_W-1:0]] <= w_ld_word;
        if (w_req_fire) r_rd_data <= r_mem[req_addr_i[ADDR_W+1:2]];
    end

    always_comb begin
        w_push_data.instr = r_rd_err ? NOP_INSTR : r_rd_data;
        w_push_data.addr  = r_rd_addr;
        w_push_data.err   = r_rd_err;
    end

    rsp_fifo2 u_rsp_fifo (
        .clk_i       (clk_i),
        .PCrst_i     (PCrst_i),
        .push_i      (r_inflight),
        .push_data_i (w_push_data),
        .pop_i       (w_pop),
        .valid_o     (w_fifo_valid),
        .data_o      (w_head),
        .count_o     (w_fifo_count)
    );

    assign rsp_valid_o = w_fifo_valid;
    assign rsp_instr_o = w_head.instr;
    assign rsp_addr_o  = w_head.addr;
    assign rsp_err_o   = w_head.err;

    // ---------------- Load assembler ----------------
    assign w_ld_fire  = ld_valid_i & ld_ready_o;
    assign w_word_end = (r_ld_idx == 2'd3) | ld_last_i;
    assign w_ram_we   = w_ld_fire & w_word_end & ~r_ld_ptr[ADDR_W];

    // Bytes above the current index are zero so a short final word is padded.
    always_comb begin
        case (r_ld_idx)
            2'd0:    w_ld_word = {24'h0, ld_byte_i};
            2'd1:    w_ld_word = {16'h0, ld_byte_i, r_ld_acc[7:0]};
            2'd2:    w_ld_word = {8'h0, ld_byte_i, r_ld_acc[15:0]};
            default: w_ld_word = {ld_byte_i, r_ld_acc};
        endcase
    end

    always_ff @(posedge clk_i or negedge PCrst_i) begin
        if (!PCrst_i) begin
            r_ld_ptr  <= '0;
            r_ld_idx  <= 2'd0;
            r_ld_acc  <= 24'h0;
            r_ld_done <= 1'b0;
            r_ld_ovf  <= 1'b0;
        end else begin
            r_ld_done <= w_ld_fire & ld_last_i;
            if (w_run && ld_start_i) begin
                r_ld_ptr <= '0;
                r_ld_idx <= 2'd0;
                r_ld_ovf <= 1'b0;
            end else if (w_ld_fire) begin
                if (w_word_end) begin
                    r_ld_idx <= 2'd0;
                    if (r_ld_ptr[ADDR_W]) r_ld_ovf <= 1'b1;
                    else                  r_ld_ptr <= r_ld_ptr + {{ADDR_W{1'b0}}, 1'b1};
                end else begin
                    r_ld_idx <= r_ld_idx + 2'd1;
                    case (r_ld_idx)
                        2'd0:    r_ld_acc[7:0]   <= ld_byte_i;
                        2'd1:    r_ld_acc[15:8]  <= ld_byte_i;
                        default: r_ld_acc[23:16] <= ld_byte_i;
                    endcase
                end
            end
        end
    end

    assign ld_done_o = r_ld_done;
    assign ld_ovf_o  = r_ld_ovf;

endmodule

`default_nettype wire
